// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefDw    = 32;
  localparam int unsigned DefDepth = 32;
  localparam int unsigned DefAw    = $clog2(DefDepth);

  typedef logic [DefAw-1:0] reg_addr_t;
  typedef logic [DefDw-1:0] reg_data_t;

  // True when addr names the hardwired-zero register and that feature is enabled.
  function automatic logic is_zero_reg(input int unsigned addr, input logic zero_reg_en);
    return zero_reg_en && (addr == 0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by issue, cleared by writeback, set wins on a collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned  DEPTH    = DefDepth,
  parameter int unsigned  NRD      = 2,
  parameter int unsigned  ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sb_set_i,
  input  logic [AW-1:0]     sb_addr_i,
  input  logic [1:0]        clr_en_i,
  input  logic [2*AW-1:0]   clr_addr_i,
  input  logic [NRD*AW-1:0] lk_addr_i,
  output logic [NRD-1:0]    lk_pending_o
);

  logic [DEPTH-1:0] pending_q, pending_d;

  // Next pending state: clears first, then the set so a newer producer overrides writeback.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned p = 0; p < 2; p++) begin
      if (clr_en_i[p]) begin
        pending_d[clr_addr_i[p*AW +: AW]] = 1'b0;
      end
    end
    if (sb_set_i && !is_zero_reg(32'(sb_addr_i), ZERO_REG != 0)) begin
      pending_d[sb_addr_i] = 1'b1;
    end
  end

  // Pending-bit storage, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Raw pending lookup for each read port; bypass masking happens in the top level.
  always_comb begin
    lk_pending_o = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      lk_pending_o[k] = pending_q[lk_addr_i[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two prioritised writes, optional
// write-to-read bypass, pending scoreboard and an unbypassed debug tap.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned  DW       = DefDw,
  parameter int unsigned  DEPTH    = DefDepth,
  parameter int unsigned  NRD      = 2,
  parameter int unsigned  ZERO_REG = 1,
  parameter int unsigned  BYPASS   = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [1:0]        wr_en,
  input  logic [2*AW-1:0]   wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  logic [DW-1:0]  mem_q [DEPTH];
  logic [DW-1:0]  mem_d [DEPTH];
  logic [NRD-1:0] rd_pend;
  logic [NRD-1:0] rd_hit;

  // Write merge: port 1 is applied last so it wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned p = 0; p < 2; p++) begin
      if (wr_en[p] && !is_zero_reg(32'(wr_addr[p*AW +: AW]), ZERO_REG != 0)) begin
        mem_d[wr_addr[p*AW +: AW]] = wr_data[p*DW +: DW];
      end
    end
  end

  // Register array, cleared asynchronously; an edge during reset drops any write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read muxes with optional forwarding; forwarding is gated by reset so outputs read zero.
  always_comb begin
    rd_data = '0;
    rd_hit  = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_data[k*DW +: DW] = mem_q[rd_addr[k*AW +: AW]];
      if (BYPASS != 0 && reset) begin
        for (int unsigned p = 0; p < 2; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr[k*AW +: AW])) begin
            rd_data[k*DW +: DW] = wr_data[p*DW +: DW];
            rd_hit[k]           = 1'b1;
          end
        end
      end
      if (is_zero_reg(32'(rd_addr[k*AW +: AW]), ZERO_REG != 0)) begin
        rd_data[k*DW +: DW] = '0;
        rd_hit[k]           = 1'b0;
      end
    end
  end

  // A forwarded value is ready now, so it must not stall decode.
  assign rd_busy  = rd_pend & ~rd_hit;
  assign dbg_data = mem_q[dbg_addr];

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_ni       (reset),
    .sb_set_i     (sb_set),
    .sb_addr_i    (sb_addr),
    .clr_en_i     (wr_en),
    .clr_addr_i   (wr_addr),
    .lk_addr_i    (rd_addr),
    .lk_pending_o (rd_pend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (default config, and 64-bit/16-deep/4-read with no
// zero register and no bypass) checked against an array-based reference model.
module tb_regfile_mp;

  localparam int unsigned ADW = 32, ADEPTH = 32, AAW = 5, ANRD = 2;
  localparam int unsigned BDW = 64, BDEPTH = 16, BAW = 4, BNRD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Unpacked stimulus, packed onto the DUT ports below.
  int            a_ra [ANRD];
  int            a_wa [2];
  logic [ADW-1:0] a_wd [2];
  logic [1:0]    a_we;
  logic          a_sb;
  int            a_sba, a_dbg;
  int            b_ra [BNRD];
  int            b_wa [2];
  logic [BDW-1:0] b_wd [2];
  logic [1:0]    b_we;
  logic          b_sb;
  int            b_sba, b_dbg;

  logic [ANRD*AAW-1:0] a_rd_addr;
  logic [ANRD*ADW-1:0] a_rd_data;
  logic [ANRD-1:0]     a_rd_busy;
  logic [2*AAW-1:0]    a_wr_addr;
  logic [2*ADW-1:0]    a_wr_data;
  logic [AAW-1:0]      a_sb_addr, a_dbg_addr;
  logic [ADW-1:0]      a_dbg_data;
  logic [BNRD*BAW-1:0] b_rd_addr;
  logic [BNRD*BDW-1:0] b_rd_data;
  logic [BNRD-1:0]     b_rd_busy;
  logic [2*BAW-1:0]    b_wr_addr;
  logic [2*BDW-1:0]    b_wr_data;
  logic [BAW-1:0]      b_sb_addr, b_dbg_addr;
  logic [BDW-1:0]      b_dbg_data;

  always_comb begin
    a_rd_addr = '0;
    b_rd_addr = '0;
    for (int k = 0; k < int'(ANRD); k++) a_rd_addr[k*AAW +: AAW] = AAW'(a_ra[k]);
    for (int k = 0; k < int'(BNRD); k++) b_rd_addr[k*BAW +: BAW] = BAW'(b_ra[k]);
    for (int p = 0; p < 2; p++) begin
      a_wr_addr[p*AAW +: AAW] = AAW'(a_wa[p]);
      a_wr_data[p*ADW +: ADW] = a_wd[p];
      b_wr_addr[p*BAW +: BAW] = BAW'(b_wa[p]);
      b_wr_data[p*BDW +: BDW] = b_wd[p];
    end
    a_sb_addr  = AAW'(a_sba);
    a_dbg_addr = AAW'(a_dbg);
    b_sb_addr  = BAW'(b_sba);
    b_dbg_addr = BAW'(b_dbg);
  end

  regfile_mp #(
    .DW(ADW), .DEPTH(ADEPTH), .NRD(ANRD), .ZERO_REG(1), .BYPASS(1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .sb_set(a_sb),
    .sb_addr(a_sb_addr), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
  );

  regfile_mp #(
    .DW(BDW), .DEPTH(BDEPTH), .NRD(BNRD), .ZERO_REG(0), .BYPASS(0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .sb_set(b_sb),
    .sb_addr(b_sb_addr), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
  );

  // Reference model state.
  logic [ADW-1:0] ma [ADEPTH];
  bit             pa [ADEPTH];
  logic [BDW-1:0] mb [BDEPTH];
  bit             pb [BDEPTH];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (ma[i]) begin ma[i] = '0; pa[i] = 1'b0; end
    foreach (mb[i]) begin mb[i] = '0; pb[i] = 1'b0; end
  endtask

  function automatic bool_write_a(input int a);
    return (a_we[0] && a_wa[0] == a) || (a_we[1] && a_wa[1] == a);
  endfunction

  // Value decode sees this cycle on instance A: r0 is zero, else newest write wins.
  function automatic logic [ADW-1:0] a_read(input int a);
    if (a == 0) return '0;
    if (a_we[1] && a_wa[1] == a) return a_wd[1];
    if (a_we[0] && a_wa[0] == a) return a_wd[0];
    return ma[a];
  endfunction

  task automatic check_outputs(input string ph);
    for (int k = 0; k < int'(ANRD); k++) begin
      check_eq($sformatf("%s a.rd_data[%0d]", ph, k), 64'(a_rd_data[k*ADW +: ADW]),
               64'(a_read(a_ra[k])));
      check_eq($sformatf("%s a.rd_busy[%0d]", ph, k), 64'(a_rd_busy[k]),
               64'(pa[a_ra[k]] && !bool_write_a(a_ra[k])));
    end
    check_eq($sformatf("%s a.dbg", ph), 64'(a_dbg_data), 64'(ma[a_dbg]));
    for (int k = 0; k < int'(BNRD); k++) begin
      check_eq($sformatf("%s b.rd_data[%0d]", ph, k), b_rd_data[k*BDW +: BDW], mb[b_ra[k]]);
      check_eq($sformatf("%s b.rd_busy[%0d]", ph, k), 64'(b_rd_busy[k]), 64'(pb[b_ra[k]]));
    end
    check_eq($sformatf("%s b.dbg", ph), b_dbg_data, mb[b_dbg]);
  endtask

  task automatic check_zero(input string ph);
    check_eq({ph, " a.rd_data"}, 64'(a_rd_data), 64'd0);
    check_eq({ph, " a.rd_busy"}, 64'(a_rd_busy), 64'd0);
    check_eq({ph, " a.dbg"}, 64'(a_dbg_data), 64'd0);
    for (int k = 0; k < int'(BNRD); k++)
      check_eq($sformatf("%s b.rd_data[%0d]", ph, k), b_rd_data[k*BDW +: BDW], 64'd0);
    check_eq({ph, " b.rd_busy"}, 64'(b_rd_busy), 64'd0);
    check_eq({ph, " b.dbg"}, b_dbg_data, 64'd0);
  endtask

  // Architectural effect of one clock edge.
  task automatic model_commit();
    for (int p = 0; p < 2; p++) if (a_we[p] && a_wa[p] != 0) ma[a_wa[p]] = a_wd[p];
    for (int p = 0; p < 2; p++) if (a_we[p]) pa[a_wa[p]] = 1'b0;
    if (a_sb && a_sba != 0) pa[a_sba] = 1'b1;
    for (int p = 0; p < 2; p++) if (b_we[p]) mb[b_wa[p]] = b_wd[p];
    for (int p = 0; p < 2; p++) if (b_we[p]) pb[b_wa[p]] = 1'b0;
    if (b_sb) pb[b_sba] = 1'b1;
  endtask

  task automatic settle(input string ph);
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic idle();
    a_we = 2'b00; a_sb = 1'b0; b_we = 2'b00; b_sb = 1'b0;
  endtask

  function automatic int pick_a();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
  endfunction

  function automatic int pick_b();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
  endfunction

  task automatic rand_inputs();
    a_we = 2'($urandom_range(0, 3));
    b_we = 2'($urandom_range(0, 3));
    for (int p = 0; p < 2; p++) begin
      a_wa[p] = pick_a();
      a_wd[p] = $urandom;
      b_wa[p] = pick_b();
      b_wd[p] = {$urandom, $urandom};
    end
    a_sb  = ($urandom_range(0, 2) == 0);
    a_sba = pick_a();
    b_sb  = ($urandom_range(0, 2) == 0);
    b_sba = pick_b();
    for (int k = 0; k < int'(ANRD); k++) a_ra[k] = pick_a();
    for (int k = 0; k < int'(BNRD); k++) b_ra[k] = pick_b();
    a_dbg = pick_a();
    b_dbg = pick_b();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    a_wa = '{0, 0}; a_wd = '{'0, '0}; a_sba = 0; a_dbg = 5; a_ra = '{5, 7};
    b_wa = '{0, 0}; b_wd = '{'0, '0}; b_sba = 0; b_dbg = 1; b_ra = '{0, 1, 2, 3};
    model_reset();
    #1;
    check_zero("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    settle("post_reset");
    commit();

    // Dual write to r7: port 1 wins, visible same cycle through bypass.
    a_we = 2'b11; a_wa = '{7, 7}; a_wd = '{32'h11, 32'h22}; a_ra = '{7, 0};
    settle("dual");
    check_eq("dual_bypass", 64'(a_rd_data[ADW-1:0]), 64'h22);
    commit();
    idle();
    settle("dual_next");
    check_eq("dual_stored", 64'(a_rd_data[ADW-1:0]), 64'h22);
    commit();

    // Writes and issue to r0: dropped on A, real register on B.
    a_we = 2'b01; a_wa = '{0, 0}; a_wd = '{32'hFFFF_FFFF, 32'h0}; a_sb = 1'b1; a_sba = 0;
    b_we = 2'b01; b_wa = '{0, 0}; b_wd = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0}; b_sb = 1'b1;
    b_sba = 0; a_ra = '{0, 0}; b_ra = '{0, 1, 2, 3};
    settle("zero");
    commit();
    idle();
    settle("zero_next");
    check_eq("zero_a_data", 64'(a_rd_data[ADW-1:0]), 64'd0);
    check_eq("zero_a_busy", 64'(a_rd_busy[0]), 64'd0);
    check_eq("zero_b_data", b_rd_data[BDW-1:0], 64'hFFFF_FFFF_FFFF_FFFF);
    commit();

    // Scoreboard round trip on r9.
    a_sb = 1'b1; a_sba = 9; a_ra = '{9, 3};
    settle("sb_set");
    commit();
    idle();
    settle("sb_pend");
    check_eq("sb_busy", 64'(a_rd_busy[0]), 64'd1);
    commit();
    a_we = 2'b01; a_wa = '{9, 0}; a_wd = '{32'h1234, 32'h0};
    settle("sb_wb");
    check_eq("sb_wb_busy", 64'(a_rd_busy[0]), 64'd0);
    check_eq("sb_wb_data", 64'(a_rd_data[ADW-1:0]), 64'h1234);
    commit();
    idle();
    settle("sb_done");
    check_eq("sb_done_busy", 64'(a_rd_busy[0]), 64'd0);
    commit();

    // Set and clear of r3 in the same cycle: stays pending with the new data.
    a_sb = 1'b1; a_sba = 3; a_ra = '{3, 9};
    settle("coll_a");
    commit();
    a_we = 2'b10; a_wa = '{0, 3}; a_wd = '{32'h0, 32'hABCD};
    settle("coll_b");
    commit();
    idle();
    settle("coll_c");
    check_eq("coll_busy", 64'(a_rd_busy[0]), 64'd1);
    check_eq("coll_data", 64'(a_rd_data[ADW-1:0]), 64'hABCD);
    commit();

    // Four distinct reads on B while two writes land: old values until the edge.
    b_we = 2'b11; b_wa = '{1, 2}; b_wd = '{64'h1111, 64'h2222};
    settle("b_pre1");
    commit();
    b_wa = '{3, 4}; b_wd = '{64'h3333, 64'h4444};
    settle("b_pre2");
    commit();
    b_wa = '{2, 3}; b_wd = '{64'hA2A2, 64'hB3B3}; b_ra = '{1, 2, 3, 4};
    settle("b_sweep");
    check_eq("b_sweep_old", b_rd_data[BDW +: BDW], 64'h2222);
    commit();
    idle();
    settle("b_sweep_next");
    check_eq("b_sweep_new", b_rd_data[2*BDW +: BDW], 64'hB3B3);
    commit();

    // Reset in the middle of operation, with a write held across an edge.
    a_we = 2'b01; a_wa = '{5, 0}; a_wd = '{32'hDEAD_BEEF, 32'h0}; a_ra = '{5, 7}; a_dbg = 5;
    settle("r5_write");
    commit();
    a_wd = '{32'h5555, 32'h0};
    b_we = 2'b01; b_wa = '{6, 0}; b_wd = '{64'h6666, 64'h0}; b_ra = '{6, 1, 2, 3};
    #2;
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("rst_edge");
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    settle("rst_after");
    check_eq("rst_lost", 64'(a_rd_data[ADW-1:0]), 64'd0);
    commit();

    // Randomised traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      settle($sformatf("rnd%0d", n));
      commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
